// File: rtl/router_pkg.sv
// Shared definitions for the Aurora serializer/deserializer pair: default widths,
// header field offsets, FSM state encoding and the routing header struct.
package router_pkg;

  localparam int NUMBER_OF_LANE         = 4;
  localparam int AURORA_DATA_WIDTH      = 64;
  localparam int SEND_DATA_WIDTH        = 1024;
  localparam int RECOGNIZE_HEADER_WIDTH = 8;
  localparam int RECOGNIZE_ROUTER_WIDTH = 4;
  localparam int ADDR_WIDTH             = 8;
  localparam int TTL_WIDTH              = 4;

  localparam int BW            = NUMBER_OF_LANE * AURORA_DATA_WIDTH;
  localparam int PAYLOAD_BEATS = SEND_DATA_WIDTH / BW;

  localparam logic [RECOGNIZE_HEADER_WIDTH-1:0] HEADER_TAG = 8'hA5;

  // Header beat, LSB first: tag | router_id | TTL | dst_addr | unused
  localparam int OFF_ROUTER = RECOGNIZE_HEADER_WIDTH;
  localparam int OFF_TTL    = OFF_ROUTER + RECOGNIZE_ROUTER_WIDTH;
  localparam int OFF_DST    = OFF_TTL + TTL_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DRAIN
  } deser_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]             dst_addr;
    logic [TTL_WIDTH-1:0]              ttl;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id;
  } hdr_t;

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready holding register for reassembled packets. A completion
// that finds the entry occupied and not being drained is dropped and flagged.
module deser_out_reg #(
  parameter int DW = 1024,
  parameter int AW = 8,
  parameter int TW = 4,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          complete_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] dst_i,
  input  logic [TW-1:0] ttl_i,
  input  logic [RW-1:0] rid_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] dst_o,
  output logic [TW-1:0] ttl_o,
  output logic [RW-1:0] rid_o,
  output logic          overflow_o,
  output logic [15:0]   pkt_count_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q;
  logic [AW-1:0] dst_q;
  logic [TW-1:0] ttl_q;
  logic [RW-1:0] rid_q;
  logic          overflow_q;
  logic [15:0]   pkt_count_q;
  logic          accept, load;

  // A slot freed by a handshake on this edge can take the new packet at once.
  assign accept  = valid_q & ready_i;
  assign load    = complete_i & (~valid_q | accept);
  assign valid_d = load | (valid_q & ~accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      dst_q       <= '0;
      ttl_q       <= '0;
      rid_q       <= '0;
      overflow_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      valid_q    <= valid_d;
      overflow_q <= complete_i & ~load;
      if (load) begin
        data_q      <= data_i;
        dst_q       <= dst_i;
        ttl_q       <= ttl_i;
        rid_q       <= rid_i;
        pkt_count_q <= pkt_count_q + 16'd1;
      end
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign dst_o       = dst_q;
  assign ttl_o       = ttl_q;
  assign rid_o       = rid_q;
  assign overflow_o  = overflow_q;
  assign pkt_count_o = pkt_count_q;

endmodule

// File: rtl/aurora_deserializer.sv
// Aurora RX deserializer: validates the header beat, reassembles payload beats into
// one packet word and hands it to the router input stage.
module aurora_deserializer
  import router_pkg::*;
#(
  parameter int NUMBER_OF_LANE         = router_pkg::NUMBER_OF_LANE,
  parameter int AURORA_DATA_WIDTH      = router_pkg::AURORA_DATA_WIDTH,
  parameter int SEND_DATA_WIDTH        = router_pkg::SEND_DATA_WIDTH,
  parameter int RECOGNIZE_HEADER_WIDTH = router_pkg::RECOGNIZE_HEADER_WIDTH,
  parameter logic [RECOGNIZE_HEADER_WIDTH-1:0] HEADER_TAG = router_pkg::HEADER_TAG,
  parameter int RECOGNIZE_ROUTER_WIDTH = router_pkg::RECOGNIZE_ROUTER_WIDTH,
  parameter int ADDR_WIDTH             = router_pkg::ADDR_WIDTH,
  parameter int TTL_WIDTH              = router_pkg::TTL_WIDTH,
  localparam int BWL                   = NUMBER_OF_LANE * AURORA_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              axis_rx_tvalid,
  input  logic                              axis_rx_tlast,
  input  logic [BWL-1:0]                    axis_rx_tdata,
  output logic                              recv_valid,
  input  logic                              recv_ready,
  output logic [SEND_DATA_WIDTH-1:0]        recv_data,
  output logic [ADDR_WIDTH-1:0]             dst_addr_recv,
  output logic [TTL_WIDTH-1:0]              TTL_recv,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
  output logic                              frame_err,
  output logic                              overflow_err,
  output logic [15:0]                       pkt_count
);

  localparam int PB = SEND_DATA_WIDTH / BWL;
  localparam int CW = (PB > 1) ? $clog2(PB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PB - 1);

  deser_state_e               state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  hdr_t                       hdr_q, hdr_d;
  logic [SEND_DATA_WIDTH-1:0] asm_q, asm_d;
  logic                       frame_err_q, frame_err_d;
  logic                       complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      asm_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      asm_q       <= asm_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    asm_d       = asm_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    if (axis_rx_tvalid) begin
      case (state_q)
        IDLE: begin
          if (axis_rx_tlast) begin
            frame_err_d = 1'b1;
          end else if (axis_rx_tdata[RECOGNIZE_HEADER_WIDTH-1:0] == HEADER_TAG) begin
            hdr_d.dst_addr  = axis_rx_tdata[OFF_DST +: ADDR_WIDTH];
            hdr_d.ttl       = axis_rx_tdata[OFF_TTL +: TTL_WIDTH];
            hdr_d.router_id = axis_rx_tdata[OFF_ROUTER +: RECOGNIZE_ROUTER_WIDTH];
            cnt_d           = '0;
            state_d         = PAYLOAD;
          end else begin
            frame_err_d = 1'b1;
            state_d     = DRAIN;
          end
        end
        PAYLOAD: begin
          // The final beat lands in asm_d so the output register sees the whole word.
          asm_d[cnt_q*BWL +: BWL] = axis_rx_tdata;
          if (axis_rx_tlast) begin
            if (cnt_q == LAST_CNT) complete    = 1'b1;
            else                   frame_err_d = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == LAST_CNT) begin
            frame_err_d = 1'b1;
            state_d     = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (axis_rx_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;

  deser_out_reg #(
    .DW (SEND_DATA_WIDTH),
    .AW (ADDR_WIDTH),
    .TW (TTL_WIDTH),
    .RW (RECOGNIZE_ROUTER_WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .complete_i  (complete),
    .data_i      (asm_d),
    .dst_i       (hdr_q.dst_addr),
    .ttl_i       (hdr_q.ttl),
    .rid_i       (hdr_q.router_id),
    .ready_i     (recv_ready),
    .valid_o     (recv_valid),
    .data_o      (recv_data),
    .dst_o       (dst_addr_recv),
    .ttl_o       (TTL_recv),
    .rid_o       (router_id_recv),
    .overflow_o  (overflow_err),
    .pkt_count_o (pkt_count)
  );

endmodule

// File: tb/tb_aurora_deserializer.sv
// Directed bench for aurora_deserializer: good frames, malformed frames, overflow,
// tvalid gaps, same-cycle drain/load and asynchronous reset mid-packet.
module tb_aurora_deserializer;

  logic          clk = 1'b0;
  logic          rst;
  logic          axis_rx_tvalid;
  logic          axis_rx_tlast;
  logic [255:0]  axis_rx_tdata;
  logic          recv_valid;
  logic          recv_ready;
  logic [1023:0] recv_data;
  logic [7:0]    dst_addr_recv;
  logic [3:0]    TTL_recv;
  logic [3:0]    router_id_recv;
  logic          frame_err;
  logic          overflow_err;
  logic [15:0]   pkt_count;

  int n_chk  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_base, ov_base;

  aurora_deserializer dut (
    .clk            (clk),
    .rst            (rst),
    .axis_rx_tvalid (axis_rx_tvalid),
    .axis_rx_tlast  (axis_rx_tlast),
    .axis_rx_tdata  (axis_rx_tdata),
    .recv_valid     (recv_valid),
    .recv_ready     (recv_ready),
    .recv_data      (recv_data),
    .dst_addr_recv  (dst_addr_recv),
    .TTL_recv       (TTL_recv),
    .router_id_recv (router_id_recv),
    .frame_err      (frame_err),
    .overflow_err   (overflow_err),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err)    fe_cnt++;
    if (overflow_err) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [255:0] hdr(input logic [7:0] tag, input logic [3:0] rid,
                                       input logic [3:0] ttl, input logic [7:0] dst);
    logic [255:0] h;
    h = '0;
    h[7:0]   = tag;
    h[11:8]  = rid;
    h[15:12] = ttl;
    h[23:16] = dst;
    return h;
  endfunction

  function automatic logic [1023:0] pkt(input logic [7:0] p0, p1, p2, p3);
    return {rep(p3), rep(p2), rep(p1), rep(p0)};
  endfunction

  task automatic beat(input logic [255:0] d, input logic l);
    axis_rx_tvalid = 1'b1;
    axis_rx_tdata  = d;
    axis_rx_tlast  = l;
    @(posedge clk);
    #1;
    axis_rx_tvalid = 1'b0;
    axis_rx_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    axis_rx_tvalid = 1'b0;
    axis_rx_tlast  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [255:0] h, input logic [7:0] p0, p1, p2, p3, input int gap);
    beat(h, 1'b0);        idle(gap);
    beat(rep(p0), 1'b0);  idle(gap);
    beat(rep(p1), 1'b0);  idle(gap);
    beat(rep(p2), 1'b0);  idle(gap);
    beat(rep(p3), 1'b1);
  endtask

  initial begin
    rst            = 1'b1;
    axis_rx_tvalid = 1'b0;
    axis_rx_tlast  = 1'b0;
    axis_rx_tdata  = '0;
    recv_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_valid", 1024'(recv_valid), 1024'(0));
    chk("rst_data",  recv_data, '0);
    chk("rst_count", 1024'(pkt_count), 1024'(0));
    chk("rst_ferr",  1024'(frame_err), 1024'(0));
    idle(1);

    // good frame
    beat(hdr(8'hA5, 4'd3, 4'd7, 8'h12), 1'b0);
    beat(rep(8'h11), 1'b0);
    beat(rep(8'h22), 1'b0);
    beat(rep(8'h33), 1'b0);
    chk("good_not_yet", 1024'(recv_valid), 1024'(0));
    beat(rep(8'h44), 1'b1);
    chk("good_valid", 1024'(recv_valid), 1024'(1));
    chk("good_dst",   1024'(dst_addr_recv), 1024'(8'h12));
    chk("good_ttl",   1024'(TTL_recv), 1024'(7));
    chk("good_rid",   1024'(router_id_recv), 1024'(3));
    chk("good_data",  recv_data, pkt(8'h11, 8'h22, 8'h33, 8'h44));
    chk("good_count", 1024'(pkt_count), 1024'(1));
    idle(2);
    chk("good_hold", 1024'(recv_valid), 1024'(1));
    recv_ready = 1'b1;
    idle(1);
    recv_ready = 1'b0;
    chk("good_drop", 1024'(recv_valid), 1024'(0));

    // early tlast on payload beat 2
    fe_base = fe_cnt;
    beat(hdr(8'hA5, 4'd1, 4'd1, 8'h01), 1'b0);
    beat(rep(8'hE1), 1'b0);
    beat(rep(8'hE2), 1'b1);
    chk("early_ferr", 1024'(frame_err), 1024'(1));
    idle(2);
    chk("early_pulses", 1024'(fe_cnt - fe_base), 1024'(1));
    chk("early_novalid", 1024'(recv_valid), 1024'(0));
    frame(hdr(8'hA5, 4'd5, 4'd2, 8'h34), 8'h55, 8'h66, 8'h77, 8'h88, 0);
    chk("after_early_valid", 1024'(recv_valid), 1024'(1));
    chk("after_early_fields", 1024'({dst_addr_recv, TTL_recv, router_id_recv}), 1024'(16'h3425));
    chk("after_early_data", recv_data, pkt(8'h55, 8'h66, 8'h77, 8'h88));
    chk("after_early_count", 1024'(pkt_count), 1024'(2));
    recv_ready = 1'b1;
    idle(1);
    recv_ready = 1'b0;

    // bad tag, 5-beat frame drained
    fe_base = fe_cnt;
    beat(hdr(8'h5A, 4'd3, 4'd7, 8'h12), 1'b0);
    chk("badtag_ferr", 1024'(frame_err), 1024'(1));
    beat(rep(8'hA5), 1'b0);
    beat(rep(8'hA5), 1'b0);
    beat(rep(8'hA5), 1'b0);
    beat(rep(8'hA5), 1'b1);
    idle(2);
    chk("badtag_pulses", 1024'(fe_cnt - fe_base), 1024'(1));
    chk("badtag_novalid", 1024'(recv_valid), 1024'(0));
    chk("badtag_count", 1024'(pkt_count), 1024'(2));

    // overflow with back-to-back frames, ready held low
    ov_base = ov_cnt;
    frame(hdr(8'hA5, 4'd1, 4'd3, 8'h56), 8'hA1, 8'hA2, 8'hA3, 8'hA4, 0);
    chk("ovf_first_valid", 1024'(recv_valid), 1024'(1));
    chk("ovf_first_count", 1024'(pkt_count), 1024'(3));
    frame(hdr(8'hA5, 4'd2, 4'd4, 8'h78), 8'hB1, 8'hB2, 8'hB3, 8'hB4, 0);
    chk("ovf_pulse", 1024'(overflow_err), 1024'(1));
    chk("ovf_held_data", recv_data, pkt(8'hA1, 8'hA2, 8'hA3, 8'hA4));
    chk("ovf_held_fields", 1024'({dst_addr_recv, TTL_recv, router_id_recv}), 1024'(16'h5631));
    chk("ovf_count", 1024'(pkt_count), 1024'(3));
    idle(1);
    chk("ovf_pulse_once", 1024'(ov_cnt - ov_base), 1024'(1));
    recv_ready = 1'b1;
    idle(1);
    recv_ready = 1'b0;
    chk("ovf_drained", 1024'(recv_valid), 1024'(0));
    idle(3);
    chk("ovf_only_first", 1024'(recv_valid), 1024'(0));

    // tvalid gaps, then ready on the completing cycle of a second packet
    ov_base = ov_cnt;
    frame(hdr(8'hA5, 4'd6, 4'd9, 8'h9A), 8'hC1, 8'hC2, 8'hC3, 8'hC4, 3);
    chk("gap_valid", 1024'(recv_valid), 1024'(1));
    chk("gap_data", recv_data, pkt(8'hC1, 8'hC2, 8'hC3, 8'hC4));
    chk("gap_count", 1024'(pkt_count), 1024'(4));
    beat(hdr(8'hA5, 4'd8, 4'd2, 8'hBC), 1'b0);
    beat(rep(8'hD1), 1'b0);
    beat(rep(8'hD2), 1'b0);
    beat(rep(8'hD3), 1'b0);
    recv_ready = 1'b1;
    beat(rep(8'hD4), 1'b1);
    chk("swap_valid", 1024'(recv_valid), 1024'(1));
    chk("swap_data", recv_data, pkt(8'hD1, 8'hD2, 8'hD3, 8'hD4));
    chk("swap_fields", 1024'({dst_addr_recv, TTL_recv, router_id_recv}), 1024'(16'hBC28));
    chk("swap_count", 1024'(pkt_count), 1024'(5));
    idle(1);
    recv_ready = 1'b0;
    chk("swap_no_ovf", 1024'(ov_cnt - ov_base), 1024'(0));
    chk("swap_drained", 1024'(recv_valid), 1024'(0));

    // asynchronous reset mid-PAYLOAD with a packet held
    frame(hdr(8'hA5, 4'd4, 4'd4, 8'h44), 8'hF1, 8'hF2, 8'hF3, 8'hF4, 0);
    beat(hdr(8'hA5, 4'd7, 4'd7, 8'h77), 1'b0);
    beat(rep(8'hE7), 1'b0);
    beat(rep(8'hE8), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 1024'(recv_valid), 1024'(0));
    chk("arst_data",  recv_data, '0);
    chk("arst_count", 1024'(pkt_count), 1024'(0));
    chk("arst_fields", 1024'({dst_addr_recv, TTL_recv, router_id_recv}), 1024'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    frame(hdr(8'hA5, 4'd9, 4'd1, 8'h21), 8'h12, 8'h34, 8'h56, 8'h78, 0);
    chk("post_rst_valid", 1024'(recv_valid), 1024'(1));
    chk("post_rst_data", recv_data, pkt(8'h12, 8'h34, 8'h56, 8'h78));
    chk("post_rst_fields", 1024'({dst_addr_recv, TTL_recv, router_id_recv}), 1024'(16'h2119));
    chk("post_rst_count", 1024'(pkt_count), 1024'(1));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
